// File: rtl/width_expand_arbiter_if.sv
// Bundle of the requester-side and consumer-side handshake signals for width_expand_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the environment driving it.
interface width_expand_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ*DEPTH-1:0] req_addr;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*WIDTH-1:0]       out_data;
  logic [DEPTH-1:0]         out_addr;
  logic [IDW-1:0]           out_id;

  modport slave (
    input  req_valid, req_data, req_addr, out_ready,
    output req_ready, out_valid, out_data, out_addr, out_id
  );

  modport master (
    output req_valid, req_data, req_addr, out_ready,
    input  req_ready, out_valid, out_data, out_addr, out_id
  );
endinterface

// File: rtl/width_expand_arbiter.sv
// Round-robin arbiter feeding one registered width-doubling stage: the granted word is emitted as {word, word}.
// Optional transfer/stall counters are compiled in with WIDTH_EXPAND_ARB_STATS_EN.
module width_expand_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  width_expand_arbiter_if.slave       bus
`ifdef WIDTH_EXPAND_ARB_STATS_EN
  ,
  output logic [15:0]                 xfer_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned SW  = IDW + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDW-1:0]      r_rr_ptr;
  logic [2*WIDTH-1:0]  r_out_data;
  logic [DEPTH-1:0]    r_out_addr;
  logic [IDW-1:0]      r_out_id;

  logic [SW-1:0]       w_scan_idx;
  logic [IDW-1:0]      w_gnt_idx;
  logic                w_found;
  logic                w_can_accept;
  logic                w_accept;
  logic                w_out_hs;
  logic [IDW-1:0]      w_rr_nxt;
  logic [WIDTH-1:0]    w_word;
  logic [DEPTH-1:0]    w_addr;
  logic [NUM_REQ-1:0]  w_req_ready;

  // Scan requesters starting at the round-robin pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_found    = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + SW'(k);
      if (w_scan_idx >= SW'(NUM_REQ)) begin
        w_scan_idx = w_scan_idx - SW'(NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_scan_idx[IDW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_word = '0;
    w_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_word = bus.req_data[i*WIDTH +: WIDTH];
        w_addr = bus.req_addr[i*DEPTH +: DEPTH];
      end
    end
  end

  assign w_can_accept = (r_state == S_EMPTY) || bus.out_ready;
  assign w_accept     = w_can_accept && w_found;
  assign w_out_hs     = (r_state == S_FULL) && bus.out_ready;
  assign w_rr_nxt     = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IDW'(1));

  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Grant is suppressed while reset is asserted, independent of the clock.
  assign bus.req_ready = rst_n ? w_req_ready : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (!w_accept && bus.out_ready) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Payload and fairness pointer move only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_addr <= '0;
      r_out_id   <= '0;
      r_rr_ptr   <= '0;
    end else if (w_accept) begin
      r_out_data <= {w_word, w_word};
      r_out_addr <= w_addr;
      r_out_id   <= w_gnt_idx;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  assign bus.out_valid = (r_state == S_FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_id    = r_out_id;

`ifdef WIDTH_EXPAND_ARB_STATS_EN
  logic [15:0] r_xfer_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == S_FULL) && !bus.out_ready;

  // Transfer count wraps; stall count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_out_hs) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign xfer_cnt  = r_xfer_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_width_expand_arbiter.sv
// Directed, table-driven bench for width_expand_arbiter (WIDTH=8, DEPTH=16, NUM_REQ=4).
// Define WIDTH_EXPAND_ARB_STATS_EN for both the design and the bench to exercise the counters.
module tb_width_expand_arbiter;

  logic clk;
  logic rst_n;

  width_expand_arbiter_if #(.WIDTH(8), .DEPTH(16), .NUM_REQ(4)) bus ();

`ifdef WIDTH_EXPAND_ARB_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] stall_cnt;
`endif

  width_expand_arbiter #(.WIDTH(8), .DEPTH(16), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef WIDTH_EXPAND_ARB_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [15:0] e_data;
    logic [15:0] e_addr;
    logic [1:0]  e_id;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                         input logic [15:0] a, input logic [1:0] id);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, " out_data"},  32'(bus.out_data),  32'(d));
    chk({tag, " out_addr"},  32'(bus.out_addr),  32'(a));
    chk({tag, " out_id"},    32'(bus.out_id),    32'(id));
  endtask

  task automatic step(input logic [3:0] rv, input logic ordy);
    bus.req_valid = rv;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // word_i / addr_i: 0->11/0001, 1->22/0002, 2->A5/0003, 3->3C/0004
    vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 16'h0000, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1111, 16'h0001, 2'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h2222, 16'h0002, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'hA5A5, 16'h0003, 2'd2};
    vecs[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'h3C3C, 16'h0004, 2'd3};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1111, 16'h0001, 2'd0};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'h2222, 16'h0002, 2'd1};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h2222, 16'h0002, 2'd1};
    vecs[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 16'hA5A5, 16'h0003, 2'd2};
    vecs[9]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 16'h3C3C, 16'h0004, 2'd3};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'h3C3C, 16'h0004, 2'd3};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'h3C3C, 16'h0004, 2'd3};
    vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'h3C3C, 16'h0004, 2'd3};
    vecs[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 16'h2222, 16'h0002, 2'd1};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 16'h2222, 16'h0002, 2'd1};
    vecs[15] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 16'h2222, 16'h0002, 2'd1};
    vecs[16] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 16'h1111, 16'h0001, 2'd0};
    vecs[17] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 16'hA5A5, 16'h0003, 2'd2};
    vecs[18] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 16'h1111, 16'h0001, 2'd0};
    vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1111, 16'h0001, 2'd0};

    bus.req_data  = {8'h3C, 8'hA5, 8'h22, 8'h11};
    bus.req_addr  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset with every requester asserting.
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready held", 32'(bus.req_ready), 32'h0);
    chk_out("reset", 1'b0, 16'h0000, 16'h0000, 2'd0);

    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      bus.req_valid = vecs[i].rv;
      bus.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].e_val, vecs[i].e_data, vecs[i].e_addr, vecs[i].e_id);
    end

    // Async reset while holding a result from requester 3.
    bus.req_valid = 4'b1000;
    bus.out_ready = 1'b0;
    #1;
    chk("pre-rst req_ready", 32'(bus.req_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk_out("pre-rst", 1'b1, 16'h3C3C, 16'h0004, 2'd3);
    #2;
    bus.req_valid = 4'b1001;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("async rst req_ready", 32'(bus.req_ready), 32'h0);
    chk("async rst out_id", 32'(bus.out_id), 32'h0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post-rst grant0", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk_out("post-rst first", 1'b1, 16'h1111, 16'h0001, 2'd0);
    chk("post-rst grant3", 32'(bus.req_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk_out("post-rst second", 1'b1, 16'h3C3C, 16'h0004, 2'd3);
    step(4'b0000, 1'b1);
    chk("drain out_valid", 32'(bus.out_valid), 32'h0);

`ifdef WIDTH_EXPAND_ARB_STATS_EN
    rst_n = 1'b0;
    #3;
    chk("stats reset xfer", 32'(xfer_cnt), 32'h0);
    chk("stats reset stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) step(4'b0001, 1'b1);
    repeat (2) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    chk("stats xfer_cnt", 32'(xfer_cnt), 32'd5);
    chk("stats stall_cnt", 32'(stall_cnt), 32'd2);
    step(4'b0001, 1'b1);
    force dut.r_stall_cnt = 16'hFFFF;
    #1;
    release dut.r_stall_cnt;
    step(4'b0000, 1'b0);
    chk("stats stall saturate", 32'(stall_cnt), 32'hFFFF);
    chk("stats xfer unchanged", 32'(xfer_cnt), 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
